dual_port_ram: RTL and testbench
================================

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits.
REQ-002 Parameter ADDR_W, default 6, address width in bits; depth is 2**ADDR_W (64 words).
REQ-003 clk  input  1  single clock; all writes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_in_A  input  DATA_W  port A write data.
REQ-006 data_in_B  input  DATA_W  port B write data.
REQ-007 addr_A  input  ADDR_W  port A address, shared by read and write.
REQ-008 addr_B  input  ADDR_W  port B address, shared by read and write.
REQ-009 mode_A  input  1  port A mode; 1 = write, 0 = read.
REQ-010 mode_B  input  1  port B mode; 1 = write, 0 = read.
REQ-011 data_out_A  output  DATA_W  port A asynchronous read data.
REQ-012 data_out_B  output  DATA_W  port B asynchronous read data.
REQ-013 Positional port order SHALL be data_in_A, data_in_B, addr_A, addr_B, mode_A, mode_B, clk, data_out_A, data_out_B, rst_n.

Function
REQ-014 Storage SHALL be 2**ADDR_W words of DATA_W bits, shared by both ports.
REQ-015 On a rising clk edge with mode_A=1, mem[addr_A] SHALL take data_in_A.
REQ-016 On a rising clk edge with mode_B=1, mem[addr_B] SHALL take data_in_B.
REQ-017 Both ports SHALL be able to write different addresses in the same cycle; both writes complete.
REQ-018 Write collision: if mode_A=mode_B=1 and addr_A==addr_B, port A data SHALL be stored. Port B data SHALL be discarded.
REQ-019 data_out_A SHALL equal mem[addr_A] combinationally (zero-cycle latency), regardless of mode_A.
REQ-020 data_out_B SHALL equal mem[addr_B] combinationally, regardless of mode_B.
REQ-021 Read-during-write at the same address SHALL show old data before the edge and new data immediately after it.
REQ-022 A read by one port of an address written by the other SHALL show the new data right after the write edge.
REQ-023 With mode=0 on both ports, memory contents SHALL be unchanged by clk.
REQ-024 Addresses SHALL be full-range (0..63); no wrap or out-of-range case exists.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear all words to 0, without waiting for a clock edge.
REQ-026 While rst_n=0, writes SHALL be ignored, and data_out_A/data_out_B SHALL read 0.
REQ-027 Reset released mid-operation SHALL take effect at the next rising edge, with no spurious write.

Structure
REQ-028 DATA_W/ADDR_W defaults SHALL be placed in a shared package (dual_port_ram_pkg) and imported.
REQ-029 The block SHALL be a single module with no sub-modules.
REQ-030 Storage SHALL be a flop array, with one write process per clock and combinational read muxes.

Verification
REQ-031 Fill test: for i=0..31, A writes addr 2i with i+5, and B writes addr 2i+1 with i+10, in the same cycle. Then read both ports with mode=0. Required: data_out_A=i+5 and data_out_B=i+10 within 1 ns of the address change.
REQ-032 Reset test: write addr 7=0xAA, then pulse rst_n low between edges. Required: data_out=0 immediately, and addr 7 reads 0 after release.
REQ-033 Collision test: A writes 0x11 and B writes 0x22 to addr 5 in the same edge. Required: both ports read 0x11.
REQ-034 Cross-port test: A writes 0x3C to addr 63, with B reading addr 63. Required: B shows 0x3C right after the edge, and the old value before it.
REQ-035 Hold test: both ports at mode=0 for 10 cycles, with data_in toggling. Required: all 64 words unchanged.

Source files
------------

// File: rtl/dual_port_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dual_port_ram_pkg
//  Description : Shared geometry defaults and port-mode encoding for the
//                dual-port RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package dual_port_ram_pkg;

    localparam int c_DEF_DATA_W = 8;
    localparam int c_DEF_ADDR_W = 6;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } port_mode_e;

endpackage
`default_nettype wire

// File: rtl/dual_port_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dual_port_ram
//  Description : Two-port flop-array RAM, synchronous writes, asynchronous
//                reads, port A wins a same-address write collision.
//  Revision    : 1.0 - initial release
// ============================================================================
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  logic [DATA_W-1:0] data_in_A,
    input  logic [DATA_W-1:0] data_in_B,
    input  logic [ADDR_W-1:0] addr_A,
    input  logic [ADDR_W-1:0] addr_B,
    input  logic              mode_A,
    input  logic              mode_B,
    input  logic              clk,
    output logic [DATA_W-1:0] data_out_A,
    output logic [DATA_W-1:0] data_out_B,
    input  logic              rst_n
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem_q [c_DEPTH];
    logic [DATA_W-1:0] w_mem_d [c_DEPTH];
    logic              w_we_a;
    logic              w_we_b;

    assign w_we_a = (mode_A == MODE_WRITE);
    assign w_we_b = (mode_B == MODE_WRITE);

    // Port A is applied last so it overrides port B on a shared address.
    always_comb begin
        w_mem_d = r_mem_q;
        if (w_we_b) begin
            w_mem_d[addr_B] = data_in_B;
        end
        if (w_we_a) begin
            w_mem_d[addr_A] = data_in_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_mem_q <= w_mem_d;
        end
    end

    assign data_out_A = r_mem_q[addr_A];
    assign data_out_B = r_mem_q[addr_B];

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_port_ram
//  Description : Self-checking bench for dual_port_ram against an array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_ram;
    import dual_port_ram_pkg::*;

    localparam int c_DW    = c_DEF_DATA_W;
    localparam int c_AW    = c_DEF_ADDR_W;
    localparam int c_DEPTH = 1 << c_AW;

    logic [c_DW-1:0] data_in_A, data_in_B;
    logic [c_AW-1:0] addr_A, addr_B;
    logic            mode_A, mode_B;
    logic            clk, rst_n;
    logic [c_DW-1:0] data_out_A, data_out_B;

    int checks = 0;
    int errors = 0;
    logic [c_DW-1:0] model [c_DEPTH];

    dual_port_ram #(.DATA_W(c_DW), .ADDR_W(c_AW)) dut (
        .data_in_A (data_in_A),
        .data_in_B (data_in_B),
        .addr_A    (addr_A),
        .addr_B    (addr_B),
        .mode_A    (mode_A),
        .mode_B    (mode_B),
        .clk       (clk),
        .data_out_A(data_out_A),
        .data_out_B(data_out_B),
        .rst_n     (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory semantics from the rules: a write lands on its address, and when
    // both ports target one address the stored value is port A's.
    task automatic model_edge();
        if (rst_n) begin
            if (mode_A && mode_B && addr_A == addr_B) begin
                model[addr_A] = data_in_A;
            end else begin
                if (mode_A) model[addr_A] = data_in_A;
                if (mode_B) model[addr_B] = data_in_B;
            end
        end
    endtask

    task automatic clock_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode_A = 1'b1; mode_B = 1'b1;
        data_in_A = 8'hFF; data_in_B = 8'hEE;
        addr_A = 6'd3; addr_B = 6'd40;
        #1;
        for (int i = 0; i < c_DEPTH; i++) model[i] = '0;
        checks++;
        if (data_out_A !== 8'h00 || data_out_B !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got A=%0h B=%0h exp 0", data_out_A, data_out_B);
        end
        // Writes held active across edges must be ignored while in reset.
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (data_out_A !== 8'h00 || data_out_B !== 8'h00) begin
            errors++;
            $display("FAIL reset_write_ignored got A=%0h B=%0h exp 0", data_out_A, data_out_B);
        end
        @(negedge clk);
        mode_A = 1'b0; mode_B = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < c_DEPTH; i += 2) begin
            addr_A = c_AW'(i); addr_B = c_AW'(i + 1);
            #1;
            checks++;
            if (data_out_A !== 8'h00 || data_out_B !== 8'h00) begin
                errors++;
                $display("FAIL reset_clear addr=%0d got A=%0h B=%0h exp 0", i, data_out_A, data_out_B);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            mode_A = 1'b1; mode_B = 1'b1;
            addr_A = c_AW'(2 * i);     data_in_A = c_DW'(i + 5);
            addr_B = c_AW'(2 * i + 1); data_in_B = c_DW'(i + 10);
            clock_edge();
        end
        @(negedge clk);
        mode_A = 1'b0; mode_B = 1'b0;
        for (int i = 0; i < 32; i++) begin
            addr_A = c_AW'(2 * i); addr_B = c_AW'(2 * i + 1);
            #1;
            checks++;
            if (data_out_A !== c_DW'(i + 5) || data_out_B !== c_DW'(i + 10)) begin
                errors++;
                $display("FAIL fill i=%0d got A=%0h B=%0h exp A=%0h B=%0h",
                         i, data_out_A, data_out_B, c_DW'(i + 5), c_DW'(i + 10));
            end
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        mode_A = 1'b1; mode_B = 1'b1;
        addr_A = 6'd5; addr_B = 6'd5;
        data_in_A = 8'h11; data_in_B = 8'h22;
        clock_edge();
        @(negedge clk);
        mode_A = 1'b0; mode_B = 1'b0;
        #1;
        checks++;
        if (data_out_A !== 8'h11 || data_out_B !== 8'h11) begin
            errors++;
            $display("FAIL collision got A=%0h B=%0h exp 11", data_out_A, data_out_B);
        end
    endtask

    task automatic test_cross_port();
        // Address 63 was filled with 31+10 = 0x29.
        @(negedge clk);
        mode_A = 1'b1; mode_B = 1'b0;
        addr_A = 6'd63; addr_B = 6'd63;
        data_in_A = 8'h3C;
        #1;
        checks++;
        if (data_out_B !== 8'h29 || data_out_A !== 8'h29) begin
            errors++;
            $display("FAIL cross_before got A=%0h B=%0h exp 29", data_out_A, data_out_B);
        end
        clock_edge();
        checks++;
        if (data_out_B !== 8'h3C || data_out_A !== 8'h3C) begin
            errors++;
            $display("FAIL cross_after got A=%0h B=%0h exp 3c", data_out_A, data_out_B);
        end
        @(negedge clk);
        mode_A = 1'b0;
    endtask

    task automatic test_hold();
        @(negedge clk);
        mode_A = 1'b0; mode_B = 1'b0;
        for (int c = 0; c < 10; c++) begin
            data_in_A = c_DW'($urandom);
            data_in_B = c_DW'($urandom);
            addr_A = c_AW'($urandom); addr_B = c_AW'($urandom);
            clock_edge();
            @(negedge clk);
        end
        for (int i = 0; i < c_DEPTH; i++) begin
            addr_A = c_AW'(i); addr_B = c_AW'(c_DEPTH - 1 - i);
            #1;
            checks++;
            if (data_out_A !== model[i] || data_out_B !== model[c_DEPTH - 1 - i]) begin
                errors++;
                $display("FAIL hold addr=%0d got A=%0h B=%0h exp A=%0h B=%0h",
                         i, data_out_A, data_out_B, model[i], model[c_DEPTH - 1 - i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mode_A = 1'b1; mode_B = 1'b0;
        addr_A = 6'd7; addr_B = 6'd7; data_in_A = 8'hAA;
        clock_edge();
        checks++;
        if (data_out_B !== 8'hAA) begin
            errors++;
            $display("FAIL pre_reset got B=%0h exp aa", data_out_B);
        end
        @(negedge clk);
        mode_A = 1'b0;
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) model[i] = '0;
        #1;
        checks++;
        if (data_out_A !== 8'h00 || data_out_B !== 8'h00) begin
            errors++;
            $display("FAIL reset_async got A=%0h B=%0h exp 0", data_out_A, data_out_B);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (data_out_A !== 8'h00) begin
            errors++;
            $display("FAIL reset_release addr7 got %0h exp 0", data_out_A);
        end
        // Release with a write pending: nothing lands until the next edge.
        @(negedge clk);
        rst_n = 1'b0;
        mode_A = 1'b1; addr_A = 6'd9; addr_B = 6'd9; data_in_A = 8'h5A;
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (data_out_B !== 8'h00) begin
            errors++;
            $display("FAIL no_spurious_write got %0h exp 0", data_out_B);
        end
        clock_edge();
        checks++;
        if (data_out_B !== 8'h5A) begin
            errors++;
            $display("FAIL write_after_release got %0h exp 5a", data_out_B);
        end
        @(negedge clk);
        mode_A = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            mode_A = 1'($urandom); mode_B = 1'($urandom);
            addr_A = c_AW'($urandom);
            addr_B = ($urandom_range(0, 3) == 0) ? addr_A : c_AW'($urandom);
            data_in_A = c_DW'($urandom); data_in_B = c_DW'($urandom);
            #1;
            checks++;
            if (data_out_A !== model[addr_A] || data_out_B !== model[addr_B]) begin
                errors++;
                $display("FAIL random_pre c=%0d got A=%0h B=%0h exp A=%0h B=%0h",
                         c, data_out_A, data_out_B, model[addr_A], model[addr_B]);
            end
            clock_edge();
            checks++;
            if (data_out_A !== model[addr_A] || data_out_B !== model[addr_B]) begin
                errors++;
                $display("FAIL random_post c=%0d got A=%0h B=%0h exp A=%0h B=%0h",
                         c, data_out_A, data_out_B, model[addr_A], model[addr_B]);
            end
        end
        @(negedge clk);
        mode_A = 1'b0; mode_B = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_collision();
        test_cross_port();
        test_hold();
        test_reset_mid();
        test_random();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
